// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//
// Framebuffer arbiter for a 320x240, 8-bit-per-pixel image shown pixel-doubled
// on a 640x480 VGA raster. Two pixels are packed per 16-bit RAM word, 160 words
// per row, 38400 words in all. A single-port synchronous RAM (1-cycle read
// latency) is shared between the display line fetcher and a drawing client.
// The display always wins arbitration. The client gets the remaining cycles.
//
// Ports
//   clk, rst              system clock; asynchronous active-low reset
//   pix_ce, x, y          pixel strobe (one clk in two) and raster position
//   pix_data, underrun    registered pixel colour; sticky FIFO-underrun flag
//   cl_valid/cl_ready     drawing-client request handshake
//   cl_we, cl_addr,       client write enable, word address, write data
//   cl_wdata
//   cl_rdata, cl_rvalid   client read return, one-cycle pulse
//   mem_en, mem_we,       registered RAM command
//   mem_addr, mem_wdata
//   mem_rdata             RAM read data, valid the cycle after the RAM edge
//
// Optional feature
//   FB_UNDERRUN_CNT_EN    adds output underrun_cnt [15:0], a saturating count of
//                         pixels that found the display FIFO empty.
//
// Timing of a grant made in cycle G (edges E1, E2, E3 follow G):
//   E1: mem_* registered.   E2: RAM samples, d2/cl_rvalid set, mem_rdata valid.
//   E3: display word written into the FIFO (client data is taken during the
//       cl_rvalid cycle directly from mem_rdata).

module vga_fb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [7:0]  pix_data,
    output logic        underrun,
    input  logic        cl_valid,
    output logic        cl_ready,
    input  logic        cl_we,
    input  logic [15:0] cl_addr,
    input  logic [15:0] cl_wdata,
    output logic [15:0] cl_rdata,
    output logic        cl_rvalid,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
`ifdef FB_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam logic [9:0]  H_ACTIVE      = 10'd640;
    localparam logic [9:0]  V_ACTIVE      = 10'd480;
    localparam logic [9:0]  V_LAST        = 10'd524;
    localparam logic [7:0]  WORDS_PER_ROW = 8'd160;
    localparam logic [15:0] FB_WORDS      = 16'd38400;

    typedef enum logic {
        ST_UNARMED,
        ST_ARMED
    } arm_state_t;

    arm_state_t state, state_next;

    logic [15:0] base;
    logic [7:0]  word_cnt;

    logic [15:0] fifo_mem [4];
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  fifo_cnt;

    logic d1, d2;
    logic c1, c1_oor;
    logic rv_oor;

    logic [9:0]  y_next;
    logic [15:0] row16;
    logic [15:0] base_next;
    logic        arm_hit;
    logic        armed;
    logic        active;
    logic [2:0]  inflight;
    logic        disp_grant;
    logic        cl_in_range;
    logic        fifo_push;
    logic        fifo_pop;
    logic        under_pixel;
    logic [15:0] head;

    // Line arm: at x=640 the fetcher is retargeted to the row feeding the next
    // line. Rows are doubled vertically, so line n shows row n>>1.
    assign y_next    = (y == V_LAST) ? 10'd0 : y + 10'd1;
    assign row16     = {7'd0, y_next[9:1]};
    assign base_next = (row16 << 7) + (row16 << 5);
    assign arm_hit   = pix_ce && (x == H_ACTIVE) && (y_next < V_ACTIVE);
    assign armed     = (state == ST_ARMED);
    assign active    = (x < H_ACTIVE) && (y < V_ACTIVE);

    // Outstanding display reads count against FIFO space so a return can never
    // find the FIFO full.
    assign inflight   = {2'd0, d1} + {2'd0, d2};
    assign disp_grant = armed && (word_cnt < WORDS_PER_ROW) && ((fifo_cnt + inflight) < 3'd4);

    // cl_ready is also gated by rst so it reads 0 throughout reset.
    assign cl_ready    = rst && cl_valid && !disp_grant;
    assign cl_in_range = (cl_addr < FB_WORDS);

    // A flush at the arm edge wins over a coinciding display return.
    assign fifo_push   = d2 && !arm_hit;
    assign fifo_pop    = pix_ce && active && armed && (fifo_cnt != 3'd0) && (x[1:0] == 2'd3);
    assign under_pixel = pix_ce && active && armed && (fifo_cnt == 3'd0);
    assign head        = fifo_mem[rd_ptr];

    // Out-of-range reads return 0; any other time the bus is held at 0.
    assign cl_rdata = (cl_rvalid && !rv_oor) ? mem_rdata : 16'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_UNARMED;
        end else begin
            state <= state_next;
        end
    end

    // Once the first arm is seen the fetcher stays armed until reset.
    always_comb begin
        state_next = state;
        if (arm_hit) begin
            state_next = ST_ARMED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base     <= 16'd0;
            word_cnt <= 8'd0;
        end else if (arm_hit) begin
            base     <= base_next;
            word_cnt <= 8'd0;
        end else if (disp_grant) begin
            word_cnt <= word_cnt + 8'd1;
        end
    end

    // RAM command register. Out-of-range client requests still handshake but
    // leave the RAM idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
        end else if (disp_grant) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= base + {8'd0, word_cnt};
            mem_wdata <= 16'd0;
        end else if (cl_ready && cl_in_range) begin
            mem_en    <= 1'b1;
            mem_we    <= cl_we;
            mem_addr  <= cl_addr;
            mem_wdata <= cl_wdata;
        end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
        end
    end

    // In-flight tags. Arming kills display tags, including one granted in the
    // arm cycle itself, so stale-row words never reach the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d1        <= 1'b0;
            d2        <= 1'b0;
            c1        <= 1'b0;
            c1_oor    <= 1'b0;
            cl_rvalid <= 1'b0;
            rv_oor    <= 1'b0;
        end else begin
            d1        <= disp_grant && !arm_hit;
            d2        <= d1 && !arm_hit;
            c1        <= cl_ready && !cl_we;
            c1_oor    <= !cl_in_range;
            cl_rvalid <= c1;
            rv_oor    <= c1_oor;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else if (arm_hit) begin
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_cnt <= fifo_cnt + {2'd0, fifo_push} - {2'd0, fifo_pop};
        end
    end

    // FIFO storage needs no reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    // Pixel output. Each word covers four pixels: two per byte because of the
    // horizontal doubling, so x[1] selects the byte and x[1:0]=3 retires it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_data <= 8'd0;
            underrun <= 1'b0;
        end else if (pix_ce) begin
            if (under_pixel) begin
                pix_data <= 8'd0;
                underrun <= 1'b1;
            end else if (active && armed) begin
                pix_data <= x[1] ? head[15:8] : head[7:0];
            end else begin
                pix_data <= 8'd0;
            end
        end
    end

`ifdef FB_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= 16'd0;
        end else if (under_pixel && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed raster/client stimulus, a RAM stub,
// a queue-based reference model compared every cycle, and literal spot checks.
// Define FB_UNDERRUN_CNT_EN to also cover the underrun counter.

module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    logic [9:0]  x, y;
    logic [7:0]  pix_data;
    logic        underrun;
    logic        cl_valid, cl_ready, cl_we;
    logic [15:0] cl_addr, cl_wdata, cl_rdata;
    logic        cl_rvalid;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
`ifdef FB_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y),
        .pix_data(pix_data), .underrun(underrun),
        .cl_valid(cl_valid), .cl_ready(cl_ready), .cl_we(cl_we),
        .cl_addr(cl_addr), .cl_wdata(cl_wdata), .cl_rdata(cl_rdata), .cl_rvalid(cl_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef FB_UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    // RAM stub: single port, synchronous, one cycle of read latency.
    logic [15:0] ram [0:38399];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit          disp;
        bit          we;
        bit          oor;
        int          addr;
        logic [15:0] wdata;
        logic [15:0] data;
        int          age;
    } op_t;

    logic [15:0] mdl_mem [0:38399];
    bit          m_armed = 0;
    int          m_base = 0;
    int          m_wc = 0;
    logic [15:0] m_fifo [$];
    op_t         m_ops [$];

    logic [7:0]  e_pix = 8'd0;
    bit          e_under = 0;
    int          e_cnt = 0;
    bit          e_mem_en = 0;
    bit          e_mem_we = 0;
    logic [15:0] e_mem_addr = 16'd0;
    logic [15:0] e_mem_wdata = 16'd0;
    bit          e_rvalid = 0;
    logic [15:0] e_rdata = 16'd0;

    function automatic int disp_outstanding();
        int n = 0;
        foreach (m_ops[i]) if (m_ops[i].disp) n++;
        return n;
    endfunction

    function automatic bit m_disp_wants();
        return m_armed && (m_wc < 160) && ((m_fifo.size() + disp_outstanding()) < 4);
    endfunction

    always @(posedge clk or negedge rst) begin
        op_t         keep [$];
        logic [15:0] returned [$];
        op_t         n;
        bit          disp_g, cl_g;
        int          yn;
        logic [15:0] hw;
        if (!rst) begin
            m_armed = 0; m_base = 0; m_wc = 0;
            m_fifo.delete(); m_ops.delete();
            e_pix = 0; e_under = 0; e_cnt = 0;
            e_mem_en = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
            e_rvalid = 0; e_rdata = 0;
        end else begin
            disp_g = m_disp_wants();
            cl_g   = cl_valid && !disp_g;
            keep.delete();
            returned.delete();
            e_rvalid = 0;
            e_rdata  = 0;
            // Operations issued last edge reach the RAM now; display words
            // reach the FIFO one edge after that.
            foreach (m_ops[i]) begin
                n = m_ops[i];
                if (n.disp) begin
                    if (n.age == 0) begin
                        n.data = mdl_mem[n.addr];
                        n.age  = 1;
                        keep.push_back(n);
                    end else begin
                        returned.push_back(n.data);
                    end
                end else if (n.oor) begin
                    e_rvalid = 1; e_rdata = 16'd0;
                end else if (n.we) begin
                    mdl_mem[n.addr] = n.wdata;
                end else begin
                    e_rvalid = 1; e_rdata = mdl_mem[n.addr];
                end
            end
            e_mem_en = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
            n = '{default: 0};
            if (disp_g) begin
                n.disp = 1; n.addr = m_base + m_wc;
                e_mem_en = 1; e_mem_addr = 16'(m_base + m_wc);
                m_wc++;
                keep.push_back(n);
            end else if (cl_g) begin
                n.we = cl_we; n.addr = int'(cl_addr); n.wdata = cl_wdata;
                if (cl_addr < 16'd38400) begin
                    e_mem_en = 1; e_mem_we = cl_we; e_mem_addr = cl_addr; e_mem_wdata = cl_wdata;
                    keep.push_back(n);
                end else if (!cl_we) begin
                    n.oor = 1;
                    keep.push_back(n);
                end
            end
            if (pix_ce) begin
                if (x < 640 && y < 480 && m_armed) begin
                    if (m_fifo.size() == 0) begin
                        e_pix = 0; e_under = 1;
                        if (e_cnt < 65535) e_cnt++;
                    end else begin
                        hw = m_fifo[0];
                        e_pix = x[1] ? hw[15:8] : hw[7:0];
                        if (x[1:0] == 2'd3) void'(m_fifo.pop_front());
                    end
                end else begin
                    e_pix = 0;
                end
            end
            foreach (returned[i]) m_fifo.push_back(returned[i]);
            if (pix_ce && x == 10'd640) begin
                yn = (y == 10'd524) ? 0 : int'(y) + 1;
                if (yn < 480) begin
                    m_armed = 1; m_base = (yn / 2) * 160; m_wc = 0;
                    m_fifo.delete();
                    for (int i = keep.size() - 1; i >= 0; i--)
                        if (keep[i].disp) keep.delete(i);
                end
            end
            m_ops = keep;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("rst_pix", pix_data, 0);
            checkOutput("rst_underrun", underrun, 0);
            checkOutput("rst_ready", cl_ready, 0);
            checkOutput("rst_rvalid", cl_rvalid, 0);
            checkOutput("rst_rdata", cl_rdata, 0);
            checkOutput("rst_mem_en", mem_en, 0);
        end else begin
            checkOutput("pix_data", pix_data, e_pix);
            checkOutput("underrun", underrun, e_under);
            checkOutput("cl_ready", cl_ready, cl_valid && !m_disp_wants());
            checkOutput("mem_en", mem_en, e_mem_en);
            if (e_mem_en) begin
                checkOutput("mem_we", mem_we, e_mem_we);
                checkOutput("mem_addr", mem_addr, e_mem_addr);
                if (e_mem_we) checkOutput("mem_wdata", mem_wdata, e_mem_wdata);
            end
            checkOutput("cl_rvalid", cl_rvalid, e_rvalid);
            if (e_rvalid) checkOutput("cl_rdata", cl_rdata, e_rdata);
`ifdef FB_UNDERRUN_CNT_EN
            checkOutput("underrun_cnt", underrun_cnt, e_cnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pixel: strobe for one clk, idle for the next.
    task automatic applyStimulus(input int px, input int py);
        pix_ce = 1'b1; x = 10'(px); y = 10'(py);
        tick();
        pix_ce = 1'b0;
        tick();
    endtask

    task automatic waitReady(output int waited, output bit ok);
        ok = 0;
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cl_ready) begin
                ok = 1;
                break;
            end
            waited++;
        end
        tick();
    endtask

    initial begin
        int  waited;
        bit  ok;
        logic [15:0] w;
        for (int i = 0; i < 38400; i++) begin
            w = 16'(i * 515) ^ 16'hBBAA;
            ram[i] = w;
            mdl_mem[i] = w;
        end
        ram[160] = 16'hDDCC;
        mdl_mem[160] = 16'hDDCC;

        // Reset held mid-frame with a client knocking.
        rst = 1'b0; pix_ce = 1'b0; x = 10'd300; y = 10'd200;
        cl_valid = 1'b1; cl_we = 1'b0; cl_addr = 16'd7; cl_wdata = 16'd0;
        for (int i = 0; i < 4; i++) applyStimulus(300 + i, 200);
        checkOutput("lit_rst_ready", cl_ready, 0);
        checkOutput("lit_rst_mem_en", mem_en, 0);
        cl_valid = 1'b0;
        x = 10'd0; y = 10'd0;
        rst = 1'b1;

        // Line 0 before any arm: black, no underrun.
        for (int px = 0; px < 32; px++) applyStimulus(px, 0);
        checkOutput("lit_prearm_pix", pix_data, 8'h00);
        checkOutput("lit_prearm_under", underrun, 0);

        // Arm on y=524 for line 0, with a client write queued behind prefill.
        pix_ce = 1'b1; x = 10'd640; y = 10'd524;
        tick();
        pix_ce = 1'b0;
        cl_valid = 1'b1; cl_we = 1'b1; cl_addr = 16'd5; cl_wdata = 16'h1234;
        waitReady(waited, ok);
        cl_valid = 1'b0; cl_we = 1'b0;
        checkOutput("lit_wr_ready_seen", ok, 1);
        checkOutput("lit_wr_prefill_wait", waited, 4);
        checkOutput("lit_wr_mem_en", mem_en, 1);
        checkOutput("lit_wr_mem_we", mem_we, 1);
        checkOutput("lit_wr_mem_addr", mem_addr, 16'd5);
        tick();
        for (int px = 641; px < 652; px++) applyStimulus(px, 524);
        for (int px = 0; px < 640; px++) begin
            applyStimulus(px, 0);
            if (px == 0) checkOutput("lit_l0_x0", pix_data, 8'hAA);
            if (px == 1) checkOutput("lit_l0_x1", pix_data, 8'hAA);
            if (px == 2) checkOutput("lit_l0_x2", pix_data, 8'hBB);
            if (px == 3) checkOutput("lit_l0_x3", pix_data, 8'hBB);
            if (px == 20) checkOutput("lit_l0_x20", pix_data, 8'h34);
            if (px == 22) checkOutput("lit_l0_x22", pix_data, 8'h12);
        end
        checkOutput("lit_l0_no_under", underrun, 0);

        // Line 1 repeats row 0, with a continuous client reading alongside.
        applyStimulus(640, 0);
        cl_valid = 1'b1; cl_we = 1'b0; cl_addr = 16'd7;
        for (int px = 641; px < 652; px++) applyStimulus(px, 0);
        for (int px = 0; px < 4; px++) begin
            applyStimulus(px, 1);
            if (px == 0) checkOutput("lit_l1_x0", pix_data, 8'hAA);
            if (px == 2) checkOutput("lit_l1_x2", pix_data, 8'hBB);
        end
        cl_valid = 1'b0;
        // Arm right after a pop so a display read is in flight; line 2 = row 1.
        applyStimulus(640, 1);
        for (int px = 641; px < 652; px++) applyStimulus(px, 1);
        for (int px = 0; px < 4; px++) begin
            applyStimulus(px, 2);
            if (px == 0) checkOutput("lit_l2_x0", pix_data, 8'hCC);
            if (px == 1) checkOutput("lit_l2_x1", pix_data, 8'hCC);
            if (px == 2) checkOutput("lit_l2_x2", pix_data, 8'hDD);
        end
        applyStimulus(700, 2);
        checkOutput("lit_blank_pix", pix_data, 8'h00);
        checkOutput("lit_blank_under", underrun, 0);

        // Out-of-range client read.
        cl_valid = 1'b1; cl_we = 1'b0; cl_addr = 16'd40000;
        waitReady(waited, ok);
        cl_valid = 1'b0;
        checkOutput("lit_oor_ready_seen", ok, 1);
        checkOutput("lit_oor_mem_en", mem_en, 0);
        tick();
        checkOutput("lit_oor_rvalid", cl_rvalid, 1);
        checkOutput("lit_oor_rdata", cl_rdata, 16'h0000);
        tick();
        checkOutput("lit_oor_rvalid_drop", cl_rvalid, 0);

        // In-range client read of word 160.
        cl_valid = 1'b1; cl_we = 1'b0; cl_addr = 16'd160;
        waitReady(waited, ok);
        cl_valid = 1'b0;
        checkOutput("lit_rd_ready_seen", ok, 1);
        tick();
        checkOutput("lit_rd_rvalid", cl_rvalid, 1);
        checkOutput("lit_rd_rdata", cl_rdata, 16'hDDCC);

        // No prefill time: first pixel of line 3 finds the FIFO empty.
        applyStimulus(640, 2);
        applyStimulus(0, 3);
        checkOutput("lit_ur_pix", pix_data, 8'h00);
        checkOutput("lit_ur_flag", underrun, 1);
`ifdef FB_UNDERRUN_CNT_EN
        checkOutput("lit_ur_cnt", underrun_cnt, 16'd1);
`endif
        applyStimulus(1, 3);
        checkOutput("lit_ur_recover_pix", pix_data, 8'hCC);
        checkOutput("lit_ur_sticky", underrun, 1);

        // Reset during a client read: the read must never return.
        cl_valid = 1'b1; cl_we = 1'b0; cl_addr = 16'd3;
        waitReady(waited, ok);
        cl_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("lit_abort_under", underrun, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("lit_abort_rvalid", cl_rvalid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
